// File: rtl/poly_host_bram_port.sv
`default_nettype none
// ============================================================================
//  Module   : poly_host_bram_port
//  Purpose  : Host-side port A owner of the AMNS operand/result BRAM. Streams
//             operands in, sequences load/multiply/store, streams RES out.
//  Revision : 1.0
// ============================================================================
module poly_host_bram_port #(
    parameter int WORD_WIDTH   = 17,
    parameter int N            = 5,
    parameter int S            = 4,
    parameter int BRAM_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clock_i,
    input  logic                          reset_n_i,
    input  logic [WORD_WIDTH-1:0]         s_data_i,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    output logic [WORD_WIDTH-1:0]         m_data_o,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic                          m_last_o,
    output logic                          BRAM_we_o,
    output logic [$clog2(4*N*S+N):0]      BRAM_addr_o,
    output logic [WORD_WIDTH-1:0]         BRAM_din_o,
    input  logic [WORD_WIDTH-1:0]         BRAM_dout_i,
    output logic                          load_start_o,
    input  logic                          load_done_i,
    output logic                          mm_start_o,
    input  logic                          mm_done_i,
    output logic                          store_start_o,
    input  logic                          store_done_i,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int NS     = N * S;
    localparam int ADDR_W = $clog2(4*NS+N) + 1;
    localparam int CNT_W  = $clog2(NS+1);
    localparam int OCC_W  = $clog2(FIFO_DEPTH+BRAM_LATENCY+1);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [ADDR_W-1:0] C_IN_LAST    = ADDR_W'(3*NS+N-1);
    localparam logic [ADDR_W-1:0] C_RES_BASE   = ADDR_W'(3*NS+N);
    localparam logic [CNT_W-1:0]  C_OUT_LEN    = CNT_W'(NS);
    localparam logic [CNT_W-1:0]  C_OUT_LAST   = CNT_W'(NS-1);
    localparam logic [OCC_W-1:0]  C_FIFO_DEPTH = OCC_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]  C_PTR_LAST   = PTR_W'(FIFO_DEPTH-1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WRITE_IN = 3'd1,
        S_LOAD     = 3'd2,
        S_COMPUTE  = 3'd3,
        S_STORE    = 3'd4,
        S_READ_OUT = 3'd5
    } state_t;

    state_t                r_state;
    logic [ADDR_W-1:0]     r_wr_cnt;
    logic [ADDR_W-1:0]     r_rd_addr;
    logic [CNT_W-1:0]      r_issued;
    logic [CNT_W-1:0]      r_out_cnt;
    logic                  r_load_start;
    logic                  r_mm_start;
    logic                  r_store_start;
    logic                  r_done;
    logic [BRAM_LATENCY-1:0] r_vsr;
    logic [WORD_WIDTH-1:0] r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [OCC_W-1:0]      r_fifo_cnt;

    logic                  w_in_accept;
    logic                  w_issue;
    logic                  w_push;
    logic                  w_pop;
    logic [OCC_W-1:0]      w_in_flight;

    // Ready is gated by reset so every output is low while reset is held.
    assign s_ready_o   = reset_n_i & ((r_state == S_IDLE) | (r_state == S_WRITE_IN));
    assign w_in_accept = s_ready_o & s_valid_i;

    always_comb begin
        w_in_flight = '0;
        for (int i = 0; i < BRAM_LATENCY; i++) begin
            w_in_flight = w_in_flight + OCC_W'(r_vsr[i]);
        end
    end

    // Reads already in the BRAM pipeline reserve FIFO space, so a push can never overflow.
    assign w_issue = (r_state == S_READ_OUT) && (r_issued != C_OUT_LEN) &&
                     ((r_fifo_cnt + w_in_flight) < C_FIFO_DEPTH);
    assign w_push  = r_vsr[BRAM_LATENCY-1];
    assign w_pop   = m_valid_o & m_ready_i;

    assign m_valid_o     = (r_fifo_cnt != '0);
    assign m_data_o      = m_valid_o ? r_fifo[r_rptr] : '0;
    assign m_last_o      = m_valid_o && (r_out_cnt == C_OUT_LAST);
    assign BRAM_we_o     = w_in_accept;
    assign BRAM_din_o    = w_in_accept ? s_data_i : '0;
    assign BRAM_addr_o   = w_issue ? r_rd_addr : (w_in_accept ? r_wr_cnt : '0);
    assign busy_o        = (r_state != S_IDLE);
    assign load_start_o  = r_load_start;
    assign mm_start_o    = r_mm_start;
    assign store_start_o = r_store_start;
    assign done_o        = r_done;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state       <= S_IDLE;
            r_wr_cnt      <= '0;
            r_rd_addr     <= '0;
            r_issued      <= '0;
            r_out_cnt     <= '0;
            r_load_start  <= 1'b0;
            r_mm_start    <= 1'b0;
            r_store_start <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_load_start  <= 1'b0;
            r_mm_start    <= 1'b0;
            r_store_start <= 1'b0;
            r_done        <= 1'b0;
            if (w_issue) begin
                r_rd_addr <= r_rd_addr + 1'b1;
                r_issued  <= r_issued + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_in_accept) begin
                        r_wr_cnt <= ADDR_W'(1);
                        r_state  <= S_WRITE_IN;
                    end
                end
                S_WRITE_IN: begin
                    if (w_in_accept) begin
                        if (r_wr_cnt == C_IN_LAST) begin
                            r_wr_cnt     <= '0;
                            r_load_start <= 1'b1;
                            r_state      <= S_LOAD;
                        end else begin
                            r_wr_cnt <= r_wr_cnt + 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (load_done_i) begin
                        r_mm_start <= 1'b1;
                        r_state    <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    if (mm_done_i) begin
                        r_store_start <= 1'b1;
                        r_state       <= S_STORE;
                    end
                end
                S_STORE: begin
                    if (store_done_i) begin
                        r_rd_addr <= C_RES_BASE;
                        r_issued  <= '0;
                        r_out_cnt <= '0;
                        r_state   <= S_READ_OUT;
                    end
                end
                S_READ_OUT: begin
                    if (w_pop) begin
                        if (r_out_cnt == C_OUT_LAST) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_out_cnt <= r_out_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    generate
        if (BRAM_LATENCY > 1) begin : g_vsr_multi
            always_ff @(posedge clock_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    r_vsr <= '0;
                end else begin
                    r_vsr <= {r_vsr[BRAM_LATENCY-2:0], w_issue};
                end
            end
        end else begin : g_vsr_single
            always_ff @(posedge clock_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    r_vsr <= '0;
                end else begin
                    r_vsr <= w_issue;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == C_PTR_LAST) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == C_PTR_LAST) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clock_i) begin
        if (w_push) begin
            r_fifo[r_wptr] <= BRAM_dout_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_poly_host_bram_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_poly_host_bram_port
//  Purpose  : Randomized self-checking bench with BRAM and sequencer models.
//  Revision : 1.0
// ============================================================================
module tb_poly_host_bram_port;
    localparam int W        = 17;
    localparam int N        = 5;
    localparam int S        = 4;
    localparam int LAT      = 2;
    localparam int FD       = 4;
    localparam int NS       = N*S;
    localparam int IN_LEN   = 3*NS+N;
    localparam int OUT_LEN  = NS;
    localparam int RES_BASE = 3*NS+N;
    localparam int AW       = $clog2(4*NS+N)+1;
    localparam int PH_WR = 0, PH_LD = 1, PH_MM = 2, PH_ST = 3, PH_RD = 4, PH_DONE = 5;

    logic          clock_i = 1'b0;
    logic          reset_n_i = 1'b1;
    logic [W-1:0]  s_data_i = '0;
    logic          s_valid_i = 1'b1;
    logic          s_ready_o;
    logic [W-1:0]  m_data_o;
    logic          m_valid_o;
    logic          m_ready_i = 1'b0;
    logic          m_last_o;
    logic          BRAM_we_o;
    logic [AW-1:0] BRAM_addr_o;
    logic [W-1:0]  BRAM_din_o;
    logic [W-1:0]  BRAM_dout_i = '0;
    logic          load_start_o, mm_start_o, store_start_o;
    logic          load_done_i = 1'b0, mm_done_i = 1'b0, store_done_i = 1'b0;
    logic          busy_o, done_o;

    always #5 clock_i = ~clock_i;

    poly_host_bram_port #(.WORD_WIDTH(W), .N(N), .S(S), .BRAM_LATENCY(LAT), .FIFO_DEPTH(FD)) dut (
        .clock_i(clock_i), .reset_n_i(reset_n_i),
        .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_last_o(m_last_o),
        .BRAM_we_o(BRAM_we_o), .BRAM_addr_o(BRAM_addr_o), .BRAM_din_o(BRAM_din_o), .BRAM_dout_i(BRAM_dout_i),
        .load_start_o(load_start_o), .load_done_i(load_done_i),
        .mm_start_o(mm_start_o), .mm_done_i(mm_done_i),
        .store_start_o(store_start_o), .store_done_i(store_done_i),
        .busy_o(busy_o), .done_o(done_o)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Two-cycle registered BRAM, read-before-write on port A.
    logic [W-1:0] mem [0:(1<<AW)-1];
    logic [W-1:0] rd_p1 = '0;
    always @(posedge clock_i) begin
        BRAM_dout_i <= rd_p1;
        rd_p1       <= mem[BRAM_addr_o];
        if (BRAM_we_o) mem[BRAM_addr_o] = BRAM_din_o;
    end

    logic [W-1:0] sent     [IN_LEN];
    logic [W-1:0] res_vals [OUT_LEN];

    // Sequencer stand-ins: answer each start after a programmable delay.
    int dly_cfg = 3;
    bit noise_en = 0;
    int lc = -1, mc = -1, sc = -1;

    function automatic int pick();
        return (dly_cfg < 0) ? int'($urandom_range(0, 3)) : dly_cfg;
    endfunction

    always begin
        @(posedge clock_i);
        #2;
        if (!reset_n_i) begin
            lc = -1; mc = -1; sc = -1;
            load_done_i = 1'b0; mm_done_i = 1'b0; store_done_i = 1'b0;
        end else begin
            load_done_i  = noise_en ? 1'($urandom & 1) : 1'b0;
            mm_done_i    = noise_en ? 1'($urandom & 1) : 1'b0;
            store_done_i = noise_en ? 1'($urandom & 1) : 1'b0;
            if (load_start_o) lc = pick();
            if (lc == 0) begin load_done_i = 1'b1; lc = -1; end else if (lc > 0) lc--;
            if (mm_start_o) mc = pick();
            if (mc == 0) begin mm_done_i = 1'b1; mc = -1; end else if (mc > 0) mc--;
            if (store_start_o) sc = pick();
            if (sc == 0) begin store_done_i = 1'b1; sc = -1; end else if (sc > 0) sc--;
        end
    end

    // Transaction-level reference: expected phase, write index, read progress.
    int phase = PH_WR;
    int exp_wr = 0;
    bit first_cyc = 0;
    bit exp_done = 0;
    int issued = 0, consumed = 0, cyc = 0;
    bit hold = 0;
    logic [W-1:0] prev_data = '0;
    logic prev_last = 1'b0;
    int n_ld = 0, n_mm = 0, n_st = 0;
    bit tput = 0;
    logic [W-1:0] first_out = '0, last_out = '0;
    int first_rd_addr = 0;

    always @(negedge clock_i) begin
        if (!reset_n_i) begin
            chk("rst_ctrl", {s_ready_o, m_valid_o, m_last_o, BRAM_we_o, busy_o,
                             load_start_o, mm_start_o, store_start_o, done_o}, 0);
            chk("rst_addr", BRAM_addr_o, 0);
            chk("rst_din", BRAM_din_o, 0);
            chk("rst_mdata", m_data_o, 0);
            phase = PH_WR; exp_wr = 0; hold = 0;
        end else begin
            n_ld += int'(load_start_o);
            n_mm += int'(mm_start_o);
            n_st += int'(store_start_o);
            exp_done = (phase == PH_DONE);
            if (exp_done) begin phase = PH_WR; exp_wr = 0; end
            case (phase)
                PH_WR: begin
                    chk("busy_wr", busy_o, exp_wr != 0);
                    chk("s_ready_wr", s_ready_o, 1);
                    chk("pulses_wr", {load_start_o, mm_start_o, store_start_o, done_o}, {3'b000, exp_done});
                    chk("mvalid_wr", m_valid_o, 0);
                    chk("we_wr", BRAM_we_o, s_valid_i);
                    if (s_valid_i) begin
                        chk("wr_addr", BRAM_addr_o, exp_wr);
                        chk("wr_data", BRAM_din_o, sent[exp_wr]);
                        exp_wr++;
                        if (exp_wr == IN_LEN) begin phase = PH_LD; first_cyc = 1; end
                    end
                end
                PH_LD, PH_MM, PH_ST: begin
                    chk("busy_seq", busy_o, 1);
                    chk("s_ready_seq", s_ready_o, 0);
                    chk("we_seq", BRAM_we_o, 0);
                    chk("mvalid_seq", m_valid_o, 0);
                    chk("pulses_seq", {load_start_o, mm_start_o, store_start_o, done_o},
                        {phase == PH_LD && first_cyc, phase == PH_MM && first_cyc,
                         phase == PH_ST && first_cyc, 1'b0});
                    if ((phase == PH_LD && load_done_i) || (phase == PH_MM && mm_done_i) ||
                        (phase == PH_ST && store_done_i)) begin
                        if (phase == PH_ST) begin cyc = 0; issued = 0; consumed = 0; hold = 0; end
                        phase++;
                        first_cyc = 1;
                    end else begin
                        first_cyc = 0;
                    end
                end
                PH_RD: begin
                    chk("busy_rd", busy_o, 1);
                    chk("s_ready_rd", s_ready_o, 0);
                    chk("we_rd", BRAM_we_o, 0);
                    chk("pulses_rd", {load_start_o, mm_start_o, store_start_o, done_o}, 0);
                    if (BRAM_addr_o != '0) begin
                        chk("rd_count", issued < OUT_LEN, 1);
                        chk("rd_addr", BRAM_addr_o, RES_BASE + issued);
                        if (issued == 0) begin
                            chk("rd_first_cyc", cyc, 0);
                            first_rd_addr = int'(BRAM_addr_o);
                        end
                        issued++;
                        chk("rd_window", (issued - consumed) <= FD, 1);
                    end
                    if (hold) begin
                        chk("hold_valid", m_valid_o, 1);
                        chk("hold_data", m_data_o, prev_data);
                        chk("hold_last", m_last_o, prev_last);
                    end
                    if (!m_valid_o) chk("last_idle", m_last_o, 0);
                    if (m_valid_o) begin
                        chk("rd_data", m_data_o, res_vals[consumed]);
                        chk("rd_last", m_last_o, consumed == OUT_LEN-1);
                        if (tput && consumed == 0) chk("tput_first", cyc, LAT+1);
                        if (m_ready_i) begin
                            if (consumed == 0) first_out = m_data_o;
                            if (m_last_o) last_out = m_data_o;
                            consumed++;
                            if (consumed == OUT_LEN) begin
                                if (tput) chk("tput_last", cyc, LAT+OUT_LEN);
                                phase = PH_DONE;
                            end
                        end
                    end
                    hold = m_valid_o && !m_ready_i;
                    prev_data = m_data_o;
                    prev_last = m_last_o;
                    cyc++;
                end
                default: ;
            endcase
        end
    end

    task automatic run_tx(input int vmode, input int rdy_pct, input int dly, input bit tp,
                          input int abort_after, input bit rnd);
        int idx;
        int guard;
        bit hs;
        bit finished;
        for (int i = 0; i < IN_LEN; i++) sent[i] = rnd ? W'($urandom) : W'(i);
        for (int i = 0; i < OUT_LEN; i++) begin
            res_vals[i] = rnd ? W'($urandom) : W'(32'h100 + i);
            mem[RES_BASE+i] = res_vals[i];
        end
        n_ld = 0; n_mm = 0; n_st = 0;
        tput = tp; dly_cfg = dly; noise_en = 1;
        idx = 0; guard = 0;
        while (idx < IN_LEN && guard < 2000) begin
            s_data_i  = sent[idx];
            s_valid_i = (vmode == 0) ? 1'b1 : (vmode == 1) ? (guard % 2 == 0) : 1'($urandom & 1);
            hs = s_valid_i && s_ready_o;
            @(posedge clock_i);
            #1;
            if (hs) idx++;
            guard++;
        end
        noise_en = 0;
        chk("stream_complete", idx, IN_LEN);
        finished = 0;
        for (int c = 0; c < 3000 && !finished; c++) begin
            s_valid_i = 1'($urandom & 1);
            s_data_i  = W'($urandom);
            m_ready_i = (int'($urandom_range(0, 99)) < rdy_pct);
            @(posedge clock_i);
            #1;
            if (done_o) finished = 1;
            if (abort_after >= 0 && consumed >= abort_after && !finished) begin
                #2;
                reset_n_i = 1'b0;
                #1;
                chk("abort_ctrl", {s_ready_o, m_valid_o, m_last_o, BRAM_we_o, busy_o, done_o}, 0);
                chk("abort_addr", BRAM_addr_o, 0);
                chk("abort_data", m_data_o, 0);
                s_valid_i = 1'b0; m_ready_i = 1'b0;
                repeat (2) @(posedge clock_i);
                #3;
                reset_n_i = 1'b1;
                @(posedge clock_i);
                #1;
                break;
            end
        end
        s_valid_i = 1'b0;
        m_ready_i = 1'b0;
        if (abort_after < 0) begin
            chk("done_seen", finished, 1);
            chk("load_start_count", n_ld, 1);
            chk("mm_start_count", n_mm, 1);
            chk("store_start_count", n_st, 1);
            chk("words_out", consumed, OUT_LEN);
        end
        for (int i = 0; i < IN_LEN; i++) chk("bram_contents", mem[i], sent[i]);
        repeat (2) @(posedge clock_i);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        #1;
        reset_n_i = 1'b0;
        repeat (3) @(posedge clock_i);
        #3;
        reset_n_i = 1'b1;
        s_valid_i = 1'b0;
        @(posedge clock_i);
        #1;

        run_tx(0, 100, 3, 1, -1, 0);
        chk("pin_mem0", mem[0], 0);
        chk("pin_mem64", mem[64], 64);
        chk("pin_rd_base", first_rd_addr, 65);
        chk("pin_first_out", first_out, 17'h100);
        chk("pin_last_out", last_out, 17'h113);

        run_tx(1, 30, 3, 0, -1, 0);
        chk("pin_toggle_mem64", mem[64], 64);
        chk("pin_toggle_last", last_out, 17'h113);

        run_tx(2, 30, -1, 0, -1, 1);
        run_tx(0, 100, 3, 0, 7, 0);
        run_tx(2, 50, -1, 0, -1, 1);
        run_tx(0, 100, 0, 1, -1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
